alu_simd_pipe: RTL and testbench

- Parametrised, pipelined successor to the 16-bit AND/NOT/ADD/SAT datapath ALU.
- Configurable word width and lane width.
- Valid/ready handshake on input and output, plus an internal accumulator and sticky per-lane saturation flags.
- Sits between the operand register file and the writeback path of the datapath.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_simd_pipe_if.sv | 33 +++
 rtl/alu_sat_lane.sv | 35 +++
 rtl/alu_simd_pipe.sv | 133 +++++++++++++
 tb/tb_alu_simd_pipe.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the SIMD ALU pipeline: op encoding and lane saturation limits.
package alu_pkg;

   typedef enum logic [1:0] {
      OP_AND   = 2'b00,
      OP_NOT   = 2'b01,
      OP_ADD   = 2'b10,
      OP_PADDS = 2'b11
   } op_t;

   localparam int MAX_LANE_W = 64;

   // Largest positive value of a signed lane: 0 followed by all ones.
   function automatic logic [MAX_LANE_W-1:0] lane_sat_pos(input int lane_w);
      return (MAX_LANE_W'(1) << (lane_w - 1)) - MAX_LANE_W'(1);
   endfunction

   // Most negative value of a signed lane: 1 followed by all zeros.
   function automatic logic [MAX_LANE_W-1:0] lane_sat_neg(input int lane_w);
      return MAX_LANE_W'(1) << (lane_w - 1);
   endfunction

endpackage

// File: rtl/alu_simd_pipe_if.sv
// Operand/result handshake bundle between the register file, the ALU and writeback.
interface alu_simd_pipe_if #(
   parameter int WIDTH  = 16,
   parameter int LANE_W = 8
);
   import alu_pkg::*;

   localparam int NUM_LANES = WIDTH / LANE_W;

   logic                 in_valid;
   logic                 in_ready;
   op_t                  op;
   logic                 use_acc;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 out_valid;
   logic                 out_ready;
   logic [WIDTH-1:0]     result;
   logic [NUM_LANES-1:0] ovf;
   logic [NUM_LANES-1:0] sat_sticky;
   logic                 clr_sticky;

   modport master (
      output in_valid, op, use_acc, a, b, out_ready, clr_sticky,
      input  in_ready, out_valid, result, ovf, sat_sticky
   );

   modport slave (
      input  in_valid, op, use_acc, a, b, out_ready, clr_sticky,
      output in_ready, out_valid, result, ovf, sat_sticky
   );

endinterface

// File: rtl/alu_sat_lane.sv
// One adder lane: chains carry for full-width ADD, or isolates and saturates for PADDS.
module alu_sat_lane #(
   parameter int LANE_W = 8
) (
   input  logic [LANE_W-1:0] a,
   input  logic [LANE_W-1:0] b,
   input  logic              carry_in,
   input  logic              break_carry,
   output logic [LANE_W-1:0] sum,
   output logic              carry_out,
   output logic              overflow
);
   import alu_pkg::*;

   localparam logic [LANE_W-1:0] SAT_POS = LANE_W'(lane_sat_pos(LANE_W));
   localparam logic [LANE_W-1:0] SAT_NEG = LANE_W'(lane_sat_neg(LANE_W));

   logic              cin;
   logic [LANE_W:0]   full;
   logic [LANE_W-1:0] raw;

   always_comb begin
      cin       = carry_in & ~break_carry;
      full      = {1'b0, a} + {1'b0, b} + {{LANE_W{1'b0}}, cin};
      raw       = full[LANE_W-1:0];
      carry_out = full[LANE_W];
      // Same-sign operands producing an opposite-sign sum is signed overflow.
      overflow  = (a[LANE_W-1] == b[LANE_W-1]) && (raw[LANE_W-1] != a[LANE_W-1]);
      sum       = raw;
      if (break_carry && overflow) begin
         sum = a[LANE_W-1] ? SAT_NEG : SAT_POS;
      end
   end

endmodule

// File: rtl/alu_simd_pipe.sv
// Two-stage AND/NOT/ADD/PADDS ALU with valid/ready flow control, accumulator and sticky saturation flags.
module alu_simd_pipe #(
   parameter int WIDTH  = 16,
   parameter int LANE_W = 8
) (
   input  logic          clk,
   input  logic          rst,
   alu_simd_pipe_if.slave bus
);
   import alu_pkg::*;

   localparam int NUM_LANES = WIDTH / LANE_W;

   logic                 s1_valid_reg;
   op_t                  s1_op_reg;
   logic                 s1_use_acc_reg;
   logic [WIDTH-1:0]     s1_a_reg;
   logic [WIDTH-1:0]     s1_b_reg;

   logic                 s2_valid_reg;
   logic [WIDTH-1:0]     result_reg;
   logic [NUM_LANES-1:0] ovf_reg;
   logic [NUM_LANES-1:0] sticky_reg;
   logic [WIDTH-1:0]     acc_reg;

   logic                 s2_adv;
   logic                 s1_adv;
   logic                 in_ready;
   logic                 accept;
   logic                 padds;
   logic [WIDTH-1:0]     opa;
   logic [WIDTH-1:0]     lane_sum;
   logic [NUM_LANES-1:0] lane_ovf;
   logic [NUM_LANES:0]   carry;
   logic                 carry_unused;
   logic [WIDTH-1:0]     result_next;
   logic [NUM_LANES-1:0] ovf_next;

   assign s2_adv   = !s2_valid_reg || bus.out_ready;
   assign s1_adv   = s1_valid_reg && s2_adv;
   assign in_ready = !rst && (!s1_valid_reg || s2_adv);
   assign accept   = bus.in_valid && in_ready;

   // The accumulator is written at the same edge the previous op leaves S1,
   // so a back-to-back use_acc op already sees it here.
   assign opa   = s1_use_acc_reg ? acc_reg : s1_a_reg;
   assign padds = (s1_op_reg == OP_PADDS);

   assign carry[0]     = 1'b0;
   assign carry_unused = carry[NUM_LANES];

   generate
      for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
         alu_sat_lane #(
            .LANE_W (LANE_W)
         ) u_lane (
            .a           (opa[gi*LANE_W +: LANE_W]),
            .b           (s1_b_reg[gi*LANE_W +: LANE_W]),
            .carry_in    (carry[gi]),
            .break_carry (padds),
            .sum         (lane_sum[gi*LANE_W +: LANE_W]),
            .carry_out   (carry[gi+1]),
            .overflow    (lane_ovf[gi])
         );
      end
   endgenerate

   always_comb begin
      result_next = '0;
      ovf_next    = '0;
      case (s1_op_reg)
         OP_AND: result_next = opa & s1_b_reg;
         OP_NOT: result_next = ~s1_b_reg;
         OP_ADD: begin
            // With the carry chained, the top lane's overflow is the full-word overflow.
            result_next              = lane_sum;
            ovf_next[NUM_LANES-1]    = lane_ovf[NUM_LANES-1];
         end
         OP_PADDS: begin
            result_next = lane_sum;
            ovf_next    = lane_ovf;
         end
         default: begin
            result_next = '0;
            ovf_next    = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_reg   <= 1'b0;
         s1_op_reg      <= OP_AND;
         s1_use_acc_reg <= 1'b0;
         s1_a_reg       <= '0;
         s1_b_reg       <= '0;
         s2_valid_reg   <= 1'b0;
         result_reg     <= '0;
         ovf_reg        <= '0;
         sticky_reg     <= '0;
         acc_reg        <= '0;
      end else begin
         if (in_ready) begin
            s1_valid_reg <= bus.in_valid;
         end
         if (accept) begin
            s1_op_reg      <= bus.op;
            s1_use_acc_reg <= bus.use_acc;
            s1_a_reg       <= bus.a;
            s1_b_reg       <= bus.b;
         end
         if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
         end
         if (s1_adv) begin
            result_reg <= result_next;
            ovf_reg    <= ovf_next;
            acc_reg    <= result_next;
            // A new overflow survives a simultaneous clear.
            sticky_reg <= (bus.clr_sticky ? '0 : sticky_reg) | ovf_next;
         end else if (bus.clr_sticky) begin
            sticky_reg <= '0;
         end
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = s2_valid_reg;
   assign bus.result     = result_reg;
   assign bus.ovf        = ovf_reg;
   assign bus.sat_sticky = sticky_reg;

endmodule

// File: tb/tb_alu_simd_pipe.sv
// Self-checking bench for alu_simd_pipe: directed literal cases plus randomized traffic against a queue model.
module tb_alu_simd_pipe;
   import alu_pkg::*;

   localparam int W  = 16;
   localparam int L  = 8;
   localparam int NL = W / L;

   typedef struct packed {
      logic [W-1:0]  res;
      logic [NL-1:0] ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   alu_simd_pipe_if #(.WIDTH(W), .LANE_W(L)) bus ();

   alu_simd_pipe #(.WIDTH(W), .LANE_W(L)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   exp_t          q[$];
   logic [W-1:0]  m_acc     = '0;
   logic [NL-1:0] m_base    = '0;
   logic          hold_clr  = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endtask

   // Reference behaviour from the op definitions, using plain signed arithmetic.
   function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t e;
      longint s, hi, lo;
      logic signed [W-1:0] wa, wb;
      logic signed [L-1:0] la, lb;
      e.res = '0;
      e.ovf = '0;
      case (op)
         2'b00: e.res = x & y;
         2'b01: e.res = ~y;
         2'b10: begin
            wa = x; wb = y;
            s  = longint'(wa) + longint'(wb);
            hi = (longint'(1) <<< (W-1)) - 1;
            lo = -(longint'(1) <<< (W-1));
            e.res = x + y;
            e.ovf[NL-1] = (s > hi) || (s < lo);
         end
         default: begin
            hi = (longint'(1) <<< (L-1)) - 1;
            lo = -(longint'(1) <<< (L-1));
            for (int i = 0; i < NL; i++) begin
               la = x[i*L +: L]; lb = y[i*L +: L];
               s  = longint'(la) + longint'(lb);
               if (s > hi) begin s = hi; e.ovf[i] = 1'b1; end
               if (s < lo) begin s = lo; e.ovf[i] = 1'b1; end
               e.res[i*L +: L] = L'(s);
            end
         end
      endcase
      return e;
   endfunction

   // Compare process: sampled between the input drive and the next active edge.
   always begin
      exp_t e;
      logic [W-1:0] opa;
      @(negedge clk);
      #1;
      if (q.size() == 0) begin
         check("out_valid_no_pending", {31'd0, bus.out_valid}, 32'd0);
      end else if (bus.out_valid) begin
         check("model_result", {16'd0, bus.result}, {16'd0, q[0].res});
         check("model_ovf", {30'd0, bus.ovf}, {30'd0, q[0].ovf});
         check("model_sticky", {30'd0, bus.sat_sticky}, hold_clr ? 32'd0 : {30'd0, m_base | q[0].ovf});
         if (bus.out_ready) begin
            $display("xfer result=%h ovf=%b sticky=%b", bus.result, bus.ovf, bus.sat_sticky);
            if (!hold_clr) m_base = m_base | q[0].ovf;
            hold_clr = 1'b0;
            void'(q.pop_front());
         end
      end
      if (bus.clr_sticky) begin
         m_base = '0;
         if (bus.out_valid && !bus.out_ready) hold_clr = 1'b1;
      end
      if (rst) begin
         check("in_ready_in_reset", {31'd0, bus.in_ready}, 32'd0);
         q.delete();
         m_acc    = '0;
         m_base   = '0;
         hold_clr = 1'b0;
      end else if (bus.in_valid && bus.in_ready) begin
         opa = bus.use_acc ? m_acc : bus.a;
         e   = model(bus.op, opa, bus.b);
         q.push_back(e);
         m_acc = e.res;
      end
   end

   task automatic drive(input logic [1:0] op, input logic ua, input logic [W-1:0] x, input logic [W-1:0] y);
      bus.in_valid = 1'b1;
      bus.op       = op_t'(op);
      bus.use_acc  = ua;
      bus.a        = x;
      bus.b        = y;
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.use_acc  = 1'b0;
   endtask

   task automatic expect_out(input string nm, input logic [W-1:0] er, input logic [NL-1:0] eo);
      check({nm, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
      check({nm, "_result"}, {16'd0, bus.result}, {16'd0, er});
      check({nm, "_ovf"}, {30'd0, bus.ovf}, {30'd0, eo});
   endtask

   // One op into an idle pipe; result must appear exactly two cycles after accept.
   task automatic single(input string nm, input logic [1:0] op, input logic ua,
                         input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] er, input logic [NL-1:0] eo, input logic [NL-1:0] es);
      @(negedge clk); drive(op, ua, x, y); #1;
      check({nm, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
      @(negedge clk); idle(); #1;
      check({nm, "_early_valid"}, {31'd0, bus.out_valid}, 32'd0);
      @(negedge clk); #1;
      expect_out(nm, er, eo);
      check({nm, "_sticky"}, {30'd0, bus.sat_sticky}, {30'd0, es});
      $display("op %s result=%h ovf=%b sticky=%b", nm, bus.result, bus.ovf, bus.sat_sticky);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]   bp_op [4];
      logic [W-1:0] bp_a  [4];
      logic [W-1:0] bp_b  [4];
      logic [W-1:0] bp_e  [4];
      logic [W-1:0] got   [4];
      int na, nh;

      bus.in_valid = 1'b0; bus.op = OP_AND; bus.use_acc = 1'b0;
      bus.a = '0; bus.b = '0; bus.out_ready = 1'b1; bus.clr_sticky = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("reset_result", {16'd0, bus.result}, 32'd0);
      check("reset_ovf", {30'd0, bus.ovf}, 32'd0);
      check("reset_sticky", {30'd0, bus.sat_sticky}, 32'd0);
      check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);

      single("and",    2'b00, 1'b0, 16'hF0F0, 16'h3C3C, 16'h3030, 2'b00, 2'b00);
      single("not",    2'b01, 1'b0, 16'h1234, 16'h00FF, 16'hFF00, 2'b00, 2'b00);
      single("padds1", 2'b11, 1'b0, 16'h7F01, 16'h0102, 16'h7F03, 2'b10, 2'b10);
      single("padds2", 2'b11, 1'b0, 16'h8080, 16'hFFFF, 16'h8080, 2'b11, 2'b11);
      single("add1",   2'b10, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 2'b00, 2'b11);
      single("add2",   2'b10, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 2'b10, 2'b11);
      single("add3",   2'b10, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 2'b00, 2'b11);

      // Back-to-back accumulate; operand a is ignored when use_acc is set.
      @(negedge clk); drive(2'b10, 1'b0, 16'h0005, 16'h0003);
      @(negedge clk); drive(2'b10, 1'b1, 16'hFFFF, 16'h0002);
      @(negedge clk); drive(2'b11, 1'b1, 16'hFFFF, 16'h7F00); #1;
      expect_out("acc1", 16'h0008, 2'b00);
      @(negedge clk); idle(); #1;
      expect_out("acc2", 16'h000A, 2'b00);
      @(negedge clk); #1;
      expect_out("acc3", 16'h7F0A, 2'b00);

      // Backpressure: out_ready low for 5 cycles while issuing 4 ops.
      bp_op = '{2'b10, 2'b10, 2'b00, 2'b01};
      bp_a  = '{16'h0001, 16'h0002, 16'hFFFF, 16'h5555};
      bp_b  = '{16'h0001, 16'h0002, 16'h1234, 16'h0000};
      bp_e  = '{16'h0002, 16'h0004, 16'h1234, 16'hFFFF};
      na = 0; nh = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         bus.out_ready = (c >= 5);
         if (na < 4) drive(bp_op[na], 1'b0, bp_a[na], bp_b[na]); else idle();
         #1;
         if (c >= 2 && c < 5) begin
            check("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
            check("bp_accepts", na, 2);
            expect_out("bp_hold", bp_e[0], 2'b00);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (nh < 4) got[nh] = bus.result;
            nh++;
         end
         if (bus.in_valid && bus.in_ready) na++;
      end
      check("bp_delivered", nh, 4);
      for (int i = 0; i < 4; i++) check("bp_order", {16'd0, got[i]}, {16'd0, bp_e[i]});

      // Clear in the same cycle as a lane-0 overflow load: the new flag wins.
      @(negedge clk); drive(2'b11, 1'b0, 16'h007F, 16'h0001);
      @(negedge clk); idle(); bus.clr_sticky = 1'b1;
      @(negedge clk); bus.clr_sticky = 1'b0; #1;
      expect_out("clr_win", 16'h007F, 2'b01);
      check("clr_win_sticky", {30'd0, bus.sat_sticky}, 32'd1);

      // Fill both stages under backpressure, then reset.
      @(negedge clk); bus.out_ready = 1'b0; drive(2'b11, 1'b0, 16'h7F00, 16'h0100);
      @(negedge clk); drive(2'b10, 1'b0, 16'h0001, 16'h0001);
      @(negedge clk); idle(); #1;
      expect_out("full", 16'h7F00, 2'b10);
      check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("full_sticky", {30'd0, bus.sat_sticky}, 32'd3);
      @(negedge clk); rst = 1'b1; #1;
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk); rst = 1'b0; bus.out_ready = 1'b1; #1;
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_sticky", {30'd0, bus.sat_sticky}, 32'd0);
      single("rst_acc", 2'b10, 1'b1, 16'h1234, 16'h0004, 16'h0004, 2'b00, 2'b00);

      // Randomized traffic checked by the compare process.
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         rst            = ($urandom_range(0, 199) == 0);
         bus.clr_sticky = ($urandom_range(0, 15) == 0);
         bus.out_ready  = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 3) != 0)
            drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
         else
            idle();
      end

      @(negedge clk);
      rst = 1'b0; bus.clr_sticky = 1'b0; bus.out_ready = 1'b1; idle();
      for (int c = 0; c < 30 && q.size() != 0; c++) @(negedge clk);
      repeat (3) @(negedge clk);
      #2;
      check("drain_empty", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
